fetch_entry_scheduler: RTL

// - Sequences fetch responses into the instruction realigner. Sits between the I$ fetch port and
//   the realigner: buffers frontend_fetch_t entries, presents the FIFO head and holds it stable

---
 rtl/fetch_entry_scheduler_pkg.sv | 15 +
 rtl/fetch_entry_scheduler_fifo.sv | 77 +++++++
 rtl/fetch_entry_scheduler.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fetch_entry_scheduler_pkg.sv
// Shared types for the fetch entry scheduler: the fetch response payload
// handed to the realigner and the scheduler FSM state encoding.
package fetch_entry_scheduler_pkg;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] instruction;
    } frontend_fetch_t;

    typedef enum logic {
        FS_RUN,
        FS_DRAIN
    } fetch_sched_state_e;

endpackage

// File: rtl/fetch_entry_scheduler_fifo.sv
// Generic synchronous FIFO. Push into a full FIFO and pop from an empty one
// are ignored. Flush clears pointers and count and wins over push/pop.
// The head output reads as all-zero while the FIFO is empty.
module fetch_entry_scheduler_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         dtype = logic,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  dtype             data_i,
    input  logic             pop_i,
    output dtype             data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    dtype             mem_q [DEPTH];
    dtype             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer and count update; pointers wrap naturally since DEPTH is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_entry_scheduler.sv
// Fetch entry scheduler: buffers I$ fetch responses for the realigner, hands
// out request credits and drops stale in-flight responses after a flush.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FS_RUN   | no stale responses pending; every response is buffered
// FS_DRAIN | stale responses from before a flush are still in flight and
//          | the next drop_q responses are discarded
module fetch_entry_scheduler
    import fetch_entry_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    // Enables the request/response protocol checks; occupancy invariants are always checked.
    parameter bit          PROTOCOL_CHECK_EN = 1'b1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    output logic             req_ready_o,
    input  logic             req_issue_i,
    input  logic             resp_valid_i,
    input  frontend_fetch_t  resp_entry_i,
    output frontend_fetch_t  fetch_entry_o,
    output logic             fetch_entry_valid_o,
    input  logic             fetch_ack_i,
    output logic [CNT_W-1:0] occupancy_o,
    output logic             draining_o,
    output logic             overflow_o
);

    localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(DEPTH);

    fetch_sched_state_e state_q, state_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     credit_used;
    logic               fifo_full;
    logic               fifo_empty;
    logic               resp_counted;
    logic               resp_live;
    logic               push;

    // A response only retires an in-flight request if one exists, so a stray
    // response can never wrap the outstanding or drop counters.
    assign resp_counted = resp_valid_i && (outstanding_q != '0);
    assign resp_live    = resp_valid_i && !flush_i && (drop_q == '0);
    assign push         = resp_live && !fifo_full;
    assign credit_used  = {1'b0, count} + {1'b0, outstanding_q};

    assign req_ready_o         = !flush_i && (credit_used < DEPTH_EXT);
    assign fetch_entry_valid_o = !fifo_empty;
    assign occupancy_o         = count;
    assign draining_o          = (state_q == FS_DRAIN);
    assign overflow_o          = overflow_q;

    fetch_entry_scheduler_fifo #(
        .DEPTH (DEPTH),
        .dtype (frontend_fetch_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  (resp_entry_i),
        .pop_i   (fetch_ack_i),
        .data_o  (fetch_entry_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    // In-flight, stale-drop and sticky overflow bookkeeping; flush reloads drop.
    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(req_issue_i) - CNT_W'(resp_counted);
        drop_d        = drop_q;
        overflow_d    = overflow_q;
        if (flush_i) begin
            drop_d = outstanding_q - CNT_W'(resp_counted);
        end else if (resp_valid_i && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
        end
        if (resp_live && fifo_full) begin
            overflow_d = 1'b1;
        end
    end

    // Next-state logic: DRAIN lasts exactly as long as stale responses are owed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_RUN:   if (drop_d != '0) state_d = FS_DRAIN;
            FS_DRAIN: if (drop_d == '0) state_d = FS_RUN;
            default:  state_d = FS_RUN;
        endcase
    end

    // Controller state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= FS_RUN;
            outstanding_q <= '0;
            drop_q        <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            overflow_q    <= overflow_d;
        end
    end

    a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        credit_used <= DEPTH_EXT);
    a_drop_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        drop_q <= outstanding_q);

    if (PROTOCOL_CHECK_EN) begin : g_protocol_chk
        a_no_issue_on_flush: assert property (@(posedge clk_i) disable iff (rst_i)
            !(flush_i && req_issue_i));
        a_issue_has_credit: assert property (@(posedge clk_i) disable iff (rst_i)
            req_issue_i |-> req_ready_o);
        a_resp_expected: assert property (@(posedge clk_i) disable iff (rst_i)
            resp_valid_i |-> (outstanding_q != '0));
        a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
            !(resp_live && fifo_full));
    end

endmodule
